// File: rtl/dpbram_stream_reader.sv
// ---------------------------------------------------------------------------
// dpbram_stream_reader: sweeps a RAM address range on port B and re-emits the
// words as a valid/ready stream with a last flag.            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dpbram_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_enB,
  output logic [ADDR_WIDTH-1:0] o_addrB,
  input  logic [DATA_WIDTH-1:0] i_doutB,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [DATA_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_count;
  logic                  pop;
  logic                  issue;
  logic                  last_issue;
  logic [2:0]            occupancy;

  assign o_valid   = (fifo_count != 2'd0);
  assign pop       = o_valid & i_ready;
  // Slots committed after this edge; keeping it below 2 makes overflow impossible.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == READ) && (remaining != '0) && (occupancy < 3'd2);
  assign last_issue = issue && (remaining == {{ADDR_WIDTH{1'b0}}, 1'b1});

  assign o_enB   = issue;
  assign o_addrB = addr;
  assign o_data  = o_valid ? fifo_data[rd_ptr] : '0;
  assign o_last  = o_valid & fifo_last[rd_ptr];
  assign o_busy  = (state == READ) || (state == DRAIN);
  assign o_done  = (state == DONE);

  always_ff @(posedge i_clk) begin
    if (inflight) begin
      fifo_data[wr_ptr] <= i_doutB;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state         <= IDLE;
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      fifo_last     <= 2'b00;
    end else begin
      inflight      <= issue;
      inflight_last <= last_issue;
      if (inflight) begin
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
      if (issue) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            addr      <= i_base_addr;
            remaining <= i_len;
            state     <= (i_len == '0) ? DONE : READ;
          end
        end
        READ:    if (last_issue) state <= DRAIN;
        DRAIN:   if (pop && o_last) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
